ex_wb_pipeline: RTL and testbench

Downstream neighbour of the rf/alu execute block. Takes the ALU result and store data from EX, runs a one-deep MEM stage against a handshaked data memory, then a WB stage. WB drives the register-file write port (we, rw, rd). Also generates back-pressure to EX while a memory access is outstanding.

---
 rtl/ex_wb_pipeline_pkg.sv | 18 +
 rtl/ex_wb_pipeline_fwd_unit.sv | 40 ++++
 rtl/ex_wb_pipeline.sv | 125 ++++++++++++
 tb/tb_ex_wb_pipeline.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_wb_pipeline_pkg.sv
// Shared types for the EX->MEM->WB pipeline tail: MEM stage state encoding,
// forwarding select codes and default datapath widths.
package ex_wb_pipeline_pkg;

  localparam int DW_DEF = 32;
  localparam int RW_DEF = 5;

  typedef enum logic [1:0] {
    M_EMPTY = 2'd0,
    M_PASS  = 2'd1,
    M_WAIT  = 2'd2
  } mem_state_e;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

endpackage

// File: rtl/ex_wb_pipeline_fwd_unit.sv
// Forwarding select and load-use detection for the two ID-stage source
// registers, comparing against the MEM and WB destinations.
module ex_wb_fwd_unit
  import ex_wb_pipeline_pkg::*;
#(
  parameter int RW = RW_DEF
) (
  input  logic          mem_valid,
  input  logic          mem_regwrite,
  input  logic          mem_load,
  input  logic [RW-1:0] mem_rw,
  input  logic          wb_we,
  input  logic [RW-1:0] wb_rw,
  input  logic [RW-1:0] id_ra,
  input  logic [RW-1:0] id_rb,
  output logic [1:0]    fwd_a_sel,
  output logic [1:0]    fwd_b_sel,
  output logic          load_use
);

  logic mem_fwd_ok;
  logic mem_load_live;

  always_comb begin
    mem_fwd_ok    = mem_valid && mem_regwrite && !mem_load && (mem_rw != '0);
    mem_load_live = mem_valid && mem_load && (mem_rw != '0);

    // MEM is younger than WB, so it wins when both match.
    if (mem_fwd_ok && (mem_rw == id_ra))    fwd_a_sel = FWD_MEM;
    else if (wb_we && (wb_rw == id_ra))     fwd_a_sel = FWD_WB;
    else                                    fwd_a_sel = FWD_RF;

    if (mem_fwd_ok && (mem_rw == id_rb))    fwd_b_sel = FWD_MEM;
    else if (wb_we && (wb_rw == id_rb))     fwd_b_sel = FWD_WB;
    else                                    fwd_b_sel = FWD_RF;

    load_use = mem_load_live && ((mem_rw == id_ra) || (mem_rw == id_rb));
  end

endmodule

// File: rtl/ex_wb_pipeline.sv
// MEM + WB pipeline tail with a handshaked data memory and EX back-pressure.
// Define EX_WB_FWD_EN to add the forwarding / load-use ports (ex_wb_fwd_unit).
module ex_wb_pipeline
  import ex_wb_pipeline_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int RW = RW_DEF
) (
  input  logic          clk,
  input  logic          clr,
`ifdef EX_WB_FWD_EN
  input  logic [RW-1:0] id_ra,
  input  logic [RW-1:0] id_rb,
  output logic [1:0]    fwd_a_sel,
  output logic [1:0]    fwd_b_sel,
  output logic [DW-1:0] fwd_mem_data,
  output logic          load_use,
`endif
  input  logic          ex_valid,
  output logic          ex_ready,
  input  logic [DW-1:0] ex_alu_out,
  input  logic [DW-1:0] ex_qb,
  input  logic [RW-1:0] ex_rw,
  input  logic          ex_regwrite,
  input  logic          ex_mem_rd,
  input  logic          ex_mem_wr,
  output logic          dm_req,
  output logic          dm_wr,
  output logic [DW-1:0] dm_addr,
  output logic [DW-1:0] dm_wdata,
  input  logic [DW-1:0] dm_rdata,
  input  logic          dm_ready,
  output logic          wb_we,
  output logic [RW-1:0] wb_rw,
  output logic [DW-1:0] wb_rd
);

  // Handshake: an EX instruction moves into MEM on a rising edge where
  // ex_valid && ex_ready; ex_ready never looks at ex_valid, and a memory
  // access completes on an edge where dm_req && dm_ready.

  mem_state_e    state;
  logic [DW-1:0] mem_alu;
  logic [DW-1:0] mem_qb;
  logic [RW-1:0] mem_rw;
  logic          mem_regwrite;
  logic          mem_load;

  logic          mem_busy;
  logic          mem_leave;
  logic          mem_writes;
  logic          ex_fire;
  logic          ex_memop;
  logic [DW-1:0] wb_rd_next;

  always_comb begin
    mem_busy   = (state == M_WAIT) && !dm_ready;
    mem_leave  = (state == M_PASS) || ((state == M_WAIT) && dm_ready);
    mem_writes = mem_leave && mem_regwrite && (mem_rw != '0);
    ex_ready   = !mem_busy;
    ex_fire    = ex_valid && ex_ready;
    ex_memop   = ex_mem_rd || ex_mem_wr;
    wb_rd_next = mem_load ? dm_rdata : mem_alu;
  end

  assign dm_addr  = mem_alu;
  assign dm_wdata = mem_qb;

  always_ff @(posedge clk) begin
    if (clr) begin
      state        <= M_EMPTY;
      dm_req       <= 1'b0;
      dm_wr        <= 1'b0;
      mem_alu      <= '0;
      mem_qb       <= '0;
      mem_rw       <= '0;
      mem_regwrite <= 1'b0;
      mem_load     <= 1'b0;
      wb_we        <= 1'b0;
      wb_rw        <= '0;
      wb_rd        <= '0;
    end else begin
      // wb_rw/wb_rd only move on a real write so they hold across bubbles.
      wb_we <= mem_writes;
      if (mem_writes) begin
        wb_rw <= mem_rw;
        wb_rd <= wb_rd_next;
      end

      if (ex_fire) begin
        state        <= ex_memop ? M_WAIT : M_PASS;
        dm_req       <= ex_memop;
        dm_wr        <= ex_mem_wr;
        mem_alu      <= ex_alu_out;
        mem_qb       <= ex_qb;
        mem_rw       <= ex_rw;
        mem_regwrite <= ex_regwrite && !ex_mem_wr;
        mem_load     <= ex_mem_rd;
      end else if (mem_leave) begin
        state  <= M_EMPTY;
        dm_req <= 1'b0;
        dm_wr  <= 1'b0;
      end
    end
  end

`ifdef EX_WB_FWD_EN
  assign fwd_mem_data = mem_alu;

  ex_wb_fwd_unit #(.RW(RW)) u_fwd (
    .mem_valid    (state != M_EMPTY),
    .mem_regwrite (mem_regwrite),
    .mem_load     (mem_load),
    .mem_rw       (mem_rw),
    .wb_we        (wb_we),
    .wb_rw        (wb_rw),
    .id_ra        (id_ra),
    .id_rb        (id_rb),
    .fwd_a_sel    (fwd_a_sel),
    .fwd_b_sel    (fwd_b_sel),
    .load_use     (load_use)
  );
`endif

endmodule

// File: tb/tb_ex_wb_pipeline.sv
// Bench for ex_wb_pipeline: directed cases, a memory responder with
// programmable wait states, and a write-back / store scoreboard.
module tb_ex_wb_pipeline;

  localparam int DW = 32;
  localparam int RW = 5;

  logic          clk = 1'b0;
  logic          clr = 1'b1;
  logic          ex_valid = 1'b0;
  logic          ex_ready;
  logic [DW-1:0] ex_alu_out = '0;
  logic [DW-1:0] ex_qb = '0;
  logic [RW-1:0] ex_rw = '0;
  logic          ex_regwrite = 1'b0;
  logic          ex_mem_rd = 1'b0;
  logic          ex_mem_wr = 1'b0;
  logic          dm_req;
  logic          dm_wr;
  logic [DW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [DW-1:0] dm_rdata = '0;
  logic          dm_ready = 1'b0;
  logic          wb_we;
  logic [RW-1:0] wb_rw;
  logic [DW-1:0] wb_rd;
`ifdef EX_WB_FWD_EN
  logic [RW-1:0] id_ra = '0;
  logic [RW-1:0] id_rb = '0;
  logic [1:0]    fwd_a_sel;
  logic [1:0]    fwd_b_sel;
  logic [DW-1:0] fwd_mem_data;
  logic          load_use;
`endif

  ex_wb_pipeline #(.DW(DW), .RW(RW)) dut (
    .clk         (clk),
    .clr         (clr),
`ifdef EX_WB_FWD_EN
    .id_ra       (id_ra),
    .id_rb       (id_rb),
    .fwd_a_sel   (fwd_a_sel),
    .fwd_b_sel   (fwd_b_sel),
    .fwd_mem_data(fwd_mem_data),
    .load_use    (load_use),
`endif
    .ex_valid    (ex_valid),
    .ex_ready    (ex_ready),
    .ex_alu_out  (ex_alu_out),
    .ex_qb       (ex_qb),
    .ex_rw       (ex_rw),
    .ex_regwrite (ex_regwrite),
    .ex_mem_rd   (ex_mem_rd),
    .ex_mem_wr   (ex_mem_wr),
    .dm_req      (dm_req),
    .dm_wr       (dm_wr),
    .dm_addr     (dm_addr),
    .dm_wdata    (dm_wdata),
    .dm_rdata    (dm_rdata),
    .dm_ready    (dm_ready),
    .wb_we       (wb_we),
    .wb_rw       (wb_rw),
    .wb_rd       (wb_rd)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference memory / scoreboard ----------------
  logic [RW+DW-1:0] exp_q[$];
  logic [2*DW-1:0]  st_q[$];
  logic [DW-1:0]    ref_mem[logic [DW-1:0]];
  logic [DW-1:0]    dm_mem[logic [DW-1:0]];

  function automatic logic [DW-1:0] mem_init(input logic [DW-1:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  function automatic logic [DW-1:0] ref_read(input logic [DW-1:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return mem_init(a);
  endfunction

  always @(negedge clk) begin
    if (!clr && wb_we) begin
      if (exp_q.size() == 0) begin
        check("wb_unexpected", {27'd0, wb_rw, wb_rd}, 64'd0);
      end else begin
        logic [RW+DW-1:0] e;
        e = exp_q.pop_front();
        check("wb_rw", 64'(wb_rw), 64'(e[RW+DW-1:DW]));
        check("wb_rd", 64'(wb_rd), 64'(e[DW-1:0]));
      end
    end
  end

  // ---------------- memory responder ----------------
  int          fixed_lat = 1;
  int          cur_lat = 1;
  int          wait_cnt = 0;
  logic [DW-1:0] hold_addr, hold_wdata;
  logic          hold_wr;

  always @(negedge clk) begin
    dm_rdata = $urandom;
    if (clr || !dm_req) begin
      dm_ready = 1'b0;
      wait_cnt = 0;
    end else begin
      if (wait_cnt == 0) begin
        cur_lat    = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 4));
        hold_addr  = dm_addr;
        hold_wdata = dm_wdata;
        hold_wr    = dm_wr;
      end else begin
        check("dm_addr_hold", 64'(dm_addr), 64'(hold_addr));
        check("dm_wr_hold", 64'(dm_wr), 64'(hold_wr));
        if (hold_wr) check("dm_wdata_hold", 64'(dm_wdata), 64'(hold_wdata));
      end
      wait_cnt++;
      if (wait_cnt >= cur_lat) begin
        dm_ready = 1'b1;
        wait_cnt = 0;
        if (dm_wr) begin
          if (st_q.size() == 0) begin
            check("store_unexpected", 64'(dm_addr), 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            logic [2*DW-1:0] s;
            s = st_q.pop_front();
            check("st_addr", 64'(dm_addr), 64'(s[2*DW-1:DW]));
            check("st_data", 64'(dm_wdata), 64'(s[DW-1:0]));
          end
          dm_mem[dm_addr] = dm_wdata;
        end else begin
          dm_rdata = dm_mem.exists(dm_addr) ? dm_mem[dm_addr] : mem_init(dm_addr);
        end
      end else begin
        dm_ready = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      ex_valid = 1'b0;
    end
  endtask

  // Returns just after the transfer edge.
  task automatic issue(input logic [DW-1:0] alu, input logic [DW-1:0] qb,
                       input logic [RW-1:0] rw, input logic rwen,
                       input logic rd, input logic wr);
    int waited;
    @(negedge clk);
    ex_valid    = 1'b1;
    ex_alu_out  = alu;
    ex_qb       = qb;
    ex_rw       = rw;
    ex_regwrite = rwen;
    ex_mem_rd   = rd;
    ex_mem_wr   = wr;
    #1;
    waited = 0;
    while (!ex_ready && waited < 50) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!ex_ready) check("issue_timeout", 64'd0, 64'd1);
    @(posedge clk);
    if (wr) begin
      ref_mem[alu] = qb;
      st_q.push_back({alu, qb});
    end else if (rwen && rw != '0) begin
      exp_q.push_back({rw, rd ? ref_read(alu) : alu});
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (2) @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    #1;
    check("rst_wb_we", 64'(wb_we), 64'd0);
    check("rst_wb_rw", 64'(wb_rw), 64'd0);
    check("rst_wb_rd", 64'(wb_rd), 64'd0);
    check("rst_dm_req", 64'(dm_req), 64'd0);
    check("rst_ex_ready", 64'(ex_ready), 64'd1);

    // ALU op: write-back on the second edge after the transfer edge
    issue(32'h0000_0007, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0);
    idle(1);
    #1;
    check("alu_wb_we_c1", 64'(wb_we), 64'd0);
    check("alu_ex_ready_c1", 64'(ex_ready), 64'd1);
    @(negedge clk);
    #1;
    check("alu_wb_we_c2", 64'(wb_we), 64'd1);
    check("alu_ex_ready_c2", 64'(ex_ready), 64'd1);
    idle(2);

    // Load with three-cycle memory
    fixed_lat = 3;
    dm_mem[32'h100]  = 32'hDEAD_BEEF;
    ref_mem[32'h100] = 32'hDEAD_BEEF;
    issue(32'h100, 32'h0, 5'd5, 1'b1, 1'b1, 1'b0);
    idle(1);
    #1;
    check("ld_req_c1", 64'(dm_req), 64'd1);
    check("ld_wr_c1", 64'(dm_wr), 64'd0);
    check("ld_addr_c1", 64'(dm_addr), 64'h100);
    check("ld_ready_c1", 64'(ex_ready), 64'd0);
    @(negedge clk);
    #1;
    check("ld_ready_c2", 64'(ex_ready), 64'd0);
    check("ld_req_c2", 64'(dm_req), 64'd1);
    @(negedge clk);
    #1;
    check("ld_ready_c3", 64'(ex_ready), 64'd1);
    check("ld_req_c3", 64'(dm_req), 64'd1);
    check("ld_wb_we_c3", 64'(wb_we), 64'd0);
    @(negedge clk);
    #1;
    check("ld_wb_we_c4", 64'(wb_we), 64'd1);
    check("ld_wb_rd_c4", 64'(wb_rd), 64'hDEAD_BEEF);
    idle(2);

    // Store, zero-wait memory; regwrite set must still not write back
    fixed_lat = 1;
    issue(32'h40, 32'h1234, 5'd7, 1'b1, 1'b0, 1'b1);
    idle(1);
    #1;
    check("st_req", 64'(dm_req), 64'd1);
    check("st_wr", 64'(dm_wr), 64'd1);
    check("st_wdata", 64'(dm_wdata), 64'h1234);
    check("st_ex_ready", 64'(ex_ready), 64'd1);
    @(negedge clk);
    #1;
    check("st_req_done", 64'(dm_req), 64'd0);
    idle(3);

    // Register 0 is never written
    issue(32'hFFFF_FFFF, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0);
    idle(3);
    #1;
    check("r0_wb_rd_held", 64'(wb_rd), 64'hDEAD_BEEF);

    // clr in the second M_WAIT cycle abandons the load
    fixed_lat = 4;
    issue(32'h180, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0);
    idle(2);
    clr = 1'b1;
    void'(exp_q.pop_back());
    @(negedge clk);
    #1;
    clr = 1'b0;
    check("clr_dm_req", 64'(dm_req), 64'd0);
    check("clr_ex_ready", 64'(ex_ready), 64'd1);
    check("clr_wb_we", 64'(wb_we), 64'd0);
    idle(4);

`ifdef EX_WB_FWD_EN
    fixed_lat = 3;
    issue(32'h77, 32'h0, 5'd4, 1'b1, 1'b0, 1'b0);
    id_ra = 5'd4;
    id_rb = 5'd9;
    idle(1);
    #1;
    check("fwd_a_mem", 64'(fwd_a_sel), 64'd1);
    check("fwd_b_rf", 64'(fwd_b_sel), 64'd0);
    check("fwd_mem_data", 64'(fwd_mem_data), 64'h77);
    check("fwd_no_lu", 64'(load_use), 64'd0);
    @(negedge clk);
    #1;
    check("fwd_a_wb", 64'(fwd_a_sel), 64'd2);
    idle(3);
    issue(32'h300, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0);
    id_ra = 5'd1;
    id_rb = 5'd4;
    idle(1);
    #1;
    check("lu_load_use", 64'(load_use), 64'd1);
    check("lu_fwd_b_rf", 64'(fwd_b_sel), 64'd0);
    idle(5);
    id_ra = '0;
    id_rb = '0;
`endif

    // Random mix with random memory latency and EX gaps
    fixed_lat = 0;
    for (int i = 0; i < 60; i++) begin
      int kind;
      logic [DW-1:0] a;
      kind = int'($urandom_range(0, 2));
      a = 32'h200 | {27'd0, 3'($urandom_range(0, 7)), 2'b00};
      case (kind)
        0: issue($urandom, 32'h0, 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        1: issue(a, 32'h0, 5'($urandom_range(0, 7)), 1'b1, 1'b1, 1'b0);
        default: issue(a, $urandom, 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b0, 1'b1);
      endcase
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
    end
    idle(1);
    for (int i = 0; i < 100 && (exp_q.size() != 0 || st_q.size() != 0); i++) idle(1);
    idle(2);
    check("drain_exp_q", 64'(exp_q.size()), 64'd0);
    check("drain_st_q", 64'(st_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
